// File: rtl/secuenciador_mux.sv
// Microcode sequencer that drives the constant/function/accumulator mux selects, one table word per step.
// Latency: step 0 outputs appear the cycle after Bandera is sampled in IDLE, then one step per cycle.
// Backpressure: pausa freezes the step (strobes masked); abortar drops back to IDLE with no completion pulse.
//
// Optional build macro: SECUENCIADOR_REPETIR_EN -- when defined, continuo=1 on the last step
// loops back to step 0 without passing through IDLE. Undefined: continuo is ignored.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   Bandera               start request (level, sampled only in IDLE)
//   abortar, pausa        abort / freeze the running sequence (abortar wins)
//   continuo              loop request (only meaningful with SECUENCIADOR_REPETIR_EN)
//   num_pasos             sequence length, 0 or > N_PASOS means N_PASOS
//   prog_we/addr/data     microcode write port, accepted only in IDLE
//                         word layout {sel_const, sel_fun, sel_acum, senal}, MSB first
//   sel_const/fun/acum    decoded select fields of the current word (0 in IDLE)
//   Senal                 per-step strobe bit, RUN only
//   Band_Listo            high during the last step of the sequence
//   Ocupado               high in RUN or PAUSA
//   paso                  current step index
module secuenciador_mux #(
  parameter int N_PASOS = 8,
  parameter int W_CONST = 3,
  parameter int W_FUN   = 2,
  parameter int W_ACUM  = 2,
  localparam int W_MICRO = W_CONST + W_FUN + W_ACUM + 1,
  localparam int W_PASO  = $clog2(N_PASOS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Bandera,
  input  logic               abortar,
  input  logic               pausa,
  input  logic               continuo,
  input  logic [W_PASO:0]    num_pasos,
  input  logic               prog_we,
  input  logic [W_PASO-1:0]  prog_addr,
  input  logic [W_MICRO-1:0] prog_data,
  output logic [W_CONST-1:0] sel_const,
  output logic [W_FUN-1:0]   sel_fun,
  output logic [W_ACUM-1:0]  sel_acum,
  output logic               Senal,
  output logic               Band_Listo,
  output logic               Ocupado,
  output logic [W_PASO-1:0]  paso
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSA = 2'd2;

  localparam logic [W_PASO:0]   N_L      = (W_PASO+1)'(N_PASOS);
  localparam logic [W_PASO:0]   LEN_UNO  = 1;
  localparam logic [W_PASO-1:0] PASO_UNO = 1;

  // Power-on program, fields (const, fun, acum, senal).
  function automatic logic [W_MICRO-1:0] palabra_def(input int i);
    logic [W_MICRO-1:0] w;
    w = '0;
    case (i)
      0: w = {W_CONST'(5), W_FUN'(0), W_ACUM'(2), 1'b0};
      1: w = {W_CONST'(0), W_FUN'(2), W_ACUM'(0), 1'b0};
      2: w = {W_CONST'(1), W_FUN'(3), W_ACUM'(0), 1'b1};
      3: w = {W_CONST'(2), W_FUN'(1), W_ACUM'(1), 1'b0};
      4: w = {W_CONST'(3), W_FUN'(2), W_ACUM'(0), 1'b0};
      5: w = {W_CONST'(4), W_FUN'(3), W_ACUM'(0), 1'b0};
      default: w = '0;
    endcase
    return w;
  endfunction

  logic [1:0]         estado;
  logic [W_PASO:0]    len;        // length latched at the start edge
  logic [W_MICRO-1:0] tabla [N_PASOS];
  logic [W_MICRO-1:0] palabra;
  logic [W_PASO:0]    len_in;
  logic               ultimo;

  assign len_in  = (num_pasos == '0 || num_pasos > N_L) ? N_L : num_pasos;
  assign ultimo  = ({1'b0, paso} == (len - LEN_UNO));
  assign palabra = tabla[paso];

`ifndef SECUENCIADOR_REPETIR_EN
  logic unused_continuo;
  assign unused_continuo = continuo;
`endif

  // Microcode store: writes only while idle so a running sequence never sees a torn program.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_PASOS; i++) tabla[i] <= palabra_def(i);
    end else if (estado == IDLE && prog_we && ({1'b0, prog_addr} < N_L)) begin
      tabla[prog_addr] <= prog_data;
    end
  end

  // abortar outranks pausa, which outranks step advance / completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado <= IDLE;
      paso   <= '0;
      len    <= N_L;
    end else begin
      case (estado)
        IDLE: begin
          paso <= '0;
          if (Bandera) begin
            estado <= RUN;
            len    <= len_in;
          end
        end
        RUN: begin
          if (abortar) begin
            estado <= IDLE;
            paso   <= '0;
          end else if (pausa) begin
            estado <= PAUSA;
          end else if (ultimo) begin
`ifdef SECUENCIADOR_REPETIR_EN
            paso <= '0;
            if (!continuo) estado <= IDLE;
`else
            paso   <= '0;
            estado <= IDLE;
`endif
          end else begin
            paso <= paso + PASO_UNO;
          end
        end
        PAUSA: begin
          if (abortar) begin
            estado <= IDLE;
            paso   <= '0;
          end else if (!pausa) begin
            estado <= RUN;
          end
        end
        default: begin
          estado <= IDLE;
          paso   <= '0;
        end
      endcase
    end
  end

  // Outputs decode straight from state and the addressed word, so reset clears them at once.
  always_comb begin
    sel_const = '0;
    sel_fun   = '0;
    sel_acum  = '0;
    if (estado != IDLE) begin
      sel_const = palabra[W_MICRO-1 -: W_CONST];
      sel_fun   = palabra[W_FUN+W_ACUM : W_ACUM+1];
      sel_acum  = palabra[W_ACUM:1];
    end
  end

  assign Senal   = (estado == RUN) && palabra[0];
  // Masked by abortar/pausa: the step is not completing on this edge, so no completion pulse.
  assign Band_Listo = (estado == RUN) && ultimo && !abortar && !pausa;
  assign Ocupado    = (estado != IDLE);

endmodule

// File: tb/tb_secuenciador_mux.sv
module tb_secuenciador_mux;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       Bandera = 1'b0;
  logic       abortar = 1'b0;
  logic       pausa = 1'b0;
  logic       continuo = 1'b0;
  logic [3:0] num_pasos = '0;
  logic       prog_we = 1'b0;
  logic [2:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
  logic [2:0] sel_const;
  logic [1:0] sel_fun;
  logic [1:0] sel_acum;
  logic       Senal;
  logic       Band_Listo;
  logic       Ocupado;
  logic [2:0] paso;

  int nerr = 0;
  int nchk = 0;

  // Expected program, fields (const, fun, acum, senal); entry 0 is rewritten mid-test.
  int dc[8] = '{5, 0, 1, 2, 3, 4, 0, 0};
  int df[8] = '{0, 2, 3, 1, 2, 3, 0, 0};
  int da[8] = '{2, 0, 0, 1, 0, 0, 0, 0};
  int ds[8] = '{0, 0, 1, 0, 0, 0, 0, 0};

  secuenciador_mux dut (
    .clk(clk), .reset(reset), .Bandera(Bandera), .abortar(abortar), .pausa(pausa),
    .continuo(continuo), .num_pasos(num_pasos), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .sel_const(sel_const), .sel_fun(sel_fun), .sel_acum(sel_acum),
    .Senal(Senal), .Band_Listo(Band_Listo), .Ocupado(Ocupado), .paso(paso)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ex(input int c, input int f, input int a, input int s,
                                     input int bl, input int oc, input int p);
    return {19'd0, 3'(c), 2'(f), 2'(a), 1'(s), 1'(bl), 1'(oc), 3'(p)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] exp);
    #1;
    chk(tag, {19'd0, sel_const, sel_fun, sel_acum, Senal, Band_Listo, Ocupado, paso}, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic start(input logic [3:0] n);
    num_pasos = n;
    Bandera   = 1'b1;
    step();
    Bandera   = 1'b0;
  endtask

  initial begin
    int n;
    // Reset state, checked before any clock edge
    #1 reset = 1'b1;
    #2 check_out("reset_state", ex(0, 0, 0, 0, 0, 0, 0));
    step();
    step();
    reset = 1'b0;
    check_out("idle_after_reset", ex(0, 0, 0, 0, 0, 0, 0));

    // Default program, six steps
    start(4'd6);
    for (int k = 0; k < 6; k++) begin
      check_out($sformatf("seq6_p%0d", k),
                ex(dc[k], df[k], da[k], ds[k], (k == 5) ? 1 : 0, 1, k));
      step();
    end
    check_out("seq6_idle", ex(0, 0, 0, 0, 0, 0, 0));

    // Rewrite step 0 in IDLE, single-step sequence
    prog_we = 1'b1; prog_addr = 3'd0; prog_data = 8'hFF;
    step();
    prog_we = 1'b0;
    dc[0] = 7; df[0] = 3; da[0] = 3; ds[0] = 1;
    start(4'd1);
    check_out("len1_word", ex(7, 3, 3, 1, 1, 1, 0));
    step();
    check_out("len1_idle", ex(0, 0, 0, 0, 0, 0, 0));

    // Pause three cycles at step 2; length above N_PASOS clamps to 8
    start(4'd12);
    check_out("pause_p0", ex(dc[0], df[0], da[0], ds[0], 0, 1, 0));
    step();
    check_out("pause_p1", ex(dc[1], df[1], da[1], ds[1], 0, 1, 1));
    step();
    pausa = 1'b1;
    #1 chk("pause_enter_paso", {29'd0, paso}, 32'd2);
    step();
    check_out("pause_hold1", ex(1, 3, 0, 0, 0, 1, 2));
    step();
    check_out("pause_hold2", ex(1, 3, 0, 0, 0, 1, 2));
    step();
    pausa = 1'b0;
    check_out("pause_hold3", ex(1, 3, 0, 0, 0, 1, 2));
    step();
    check_out("pause_resume_p2", ex(1, 3, 0, 1, 0, 1, 2));
    step();
    for (int k = 3; k < 8; k++) begin
      check_out($sformatf("pause_p%0d", k),
                ex(dc[k], df[k], da[k], ds[k], (k == 7) ? 1 : 0, 1, k));
      step();
    end
    check_out("pause_idle", ex(0, 0, 0, 0, 0, 0, 0));

    // num_pasos = 0 runs all eight steps (bounded wait for completion)
    start(4'd0);
    n = 0;
    while (!Band_Listo && n < 20) begin
      step();
      n++;
    end
    chk("len0_cycles", n, 32'd7);
    chk("len0_last_paso", {29'd0, paso}, 32'd7);
    step();
    check_out("len0_idle", ex(0, 0, 0, 0, 0, 0, 0));

    // Abort at step 3 with a write attempted during RUN
    start(4'd6);
    step(); step(); step();
    prog_we = 1'b1; prog_addr = 3'd1; prog_data = 8'hAA;
    abortar = 1'b1;
    check_out("abort_p3", ex(2, 1, 1, 0, 0, 1, 3));
    step();
    abortar = 1'b0; prog_we = 1'b0;
    check_out("abort_idle", ex(0, 0, 0, 0, 0, 0, 0));
    start(4'd2);
    check_out("abort_tbl_p0", ex(7, 3, 3, 1, 0, 1, 0));
    step();
    check_out("abort_tbl_p1", ex(0, 2, 0, 0, 1, 1, 1));
    step();

    // Bandera held high restarts after one IDLE cycle
    num_pasos = 4'd2;
    Bandera = 1'b1;
    step();
    check_out("held_p0", ex(7, 3, 3, 1, 0, 1, 0));
    step();
    check_out("held_p1", ex(0, 2, 0, 0, 1, 1, 1));
    step();
    check_out("held_idle", ex(0, 0, 0, 0, 0, 0, 0));
    step();
    Bandera = 1'b0;
    check_out("held_restart_p0", ex(7, 3, 3, 1, 0, 1, 0));
    step();
    check_out("held_restart_p1", ex(0, 2, 0, 0, 1, 1, 1));
    step();

`ifdef SECUENCIADOR_REPETIR_EN
    // Loop mode: wraps 7 -> 0 with no IDLE gap
    continuo = 1'b1;
    start(4'd0);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 8; k++) begin
        if (r == 1 && k == 7) continuo = 1'b0;
        check_out($sformatf("loop_r%0d_p%0d", r, k),
                  ex(dc[k], df[k], da[k], ds[k], (k == 7) ? 1 : 0, 1, k));
        step();
      end
    end
    check_out("loop_idle", ex(0, 0, 0, 0, 0, 0, 0));
`else
    // continuo has no effect in this build
    continuo = 1'b1;
    start(4'd1);
    check_out("cont_ignored_p0", ex(7, 3, 3, 1, 1, 1, 0));
    step();
    check_out("cont_ignored_idle", ex(0, 0, 0, 0, 0, 0, 0));
    continuo = 1'b0;
`endif

    // Asynchronous reset mid-sequence restores outputs and the default program
    start(4'd6);
    step(); step();
    #1 reset = 1'b1;
    check_out("async_reset", ex(0, 0, 0, 0, 0, 0, 0));
    step();
    reset = 1'b0;
    start(4'd1);
    check_out("reset_tbl_p0", ex(5, 0, 2, 0, 1, 1, 0));
    step();

    // Abort from PAUSA
    start(4'd6);
    pausa = 1'b1;
    step();
    abortar = 1'b1;
    check_out("pausa_abort_hold", ex(5, 0, 2, 0, 0, 1, 0));
    step();
    abortar = 1'b0; pausa = 1'b0;
    check_out("pausa_abort_idle", ex(0, 0, 0, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/secuenciador_mux.md
SECUENCIADOR_MUX -- requirements
Module: secuenciador_mux

Interface
REQ-001 The block SHALL have parameters N_PASOS (default 8, number of microcode steps, 2..256), W_CONST (default 3, constant-select width), W_FUN (default 2, function-select width) and W_ACUM (default 2, accumulator-select width).
REQ-002 The block SHALL define W_MICRO = W_CONST+W_FUN+W_ACUM+1 and W_PASO = clog2(N_PASOS) as derived widths.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Ports SHALL be:
  clk  in  1  rising-edge clock
  reset  in  1  asynchronous active-high reset
  Bandera  in  1  start request, level sampled in IDLE
  abortar  in  1  abort the running sequence
  pausa  in  1  freeze at the current step
  continuo  in  1  loop mode request (REQ-019)
  num_pasos  in  W_PASO+1  steps to execute (0 = N_PASOS)
  prog_we  in  1  microcode write enable
  prog_addr  in  W_PASO  microcode write address
  prog_data  in  W_MICRO  word {sel_const, sel_fun, sel_acum, senal}, MSB first
  sel_const  out  W_CONST  constant mux select
  sel_fun  out  W_FUN  function mux select
  sel_acum  out  W_ACUM  accumulator mux select
  Senal  out  1  per-step strobe from the microcode
  Band_Listo  out  1  sequence-complete pulse
  Ocupado  out  1  high in RUN or PAUSA
  paso  out  W_PASO  current step index

Function
REQ-005 The FSM SHALL have states IDLE, RUN and PAUSA, with state and step counter registered on clk.
REQ-006 In IDLE, all select outputs, Senal and Band_Listo SHALL be 0, and paso SHALL be 0.
REQ-007 IDLE SHALL move to RUN when Bandera=1 at an edge, and step 0 outputs SHALL appear in the cycle following that edge (latency 1).
REQ-008 The effective length L SHALL be sampled once at the IDLE->RUN edge: num_pasos if 1..N_PASOS, N_PASOS if 0, and N_PASOS if greater than N_PASOS.
REQ-009 In RUN, the outputs SHALL be table[paso], decoded as fields, and paso SHALL advance by 1 per cycle.
REQ-010 Band_Listo SHALL be 1 exactly during the step L-1 cycle, after which the FSM SHALL return to IDLE.
REQ-011 With L=1, step 0 and Band_Listo SHALL occur in the same cycle.
REQ-012 In RUN, pausa=1 SHALL enter PAUSA: paso and the select outputs hold, and Senal and Band_Listo are forced to 0.
REQ-013 PAUSA SHALL return to RUN when pausa=0, resuming at the held step with the full microcode word, then advancing.
REQ-014 abortar=1 in RUN or PAUSA SHALL return the FSM to IDLE at the next edge without a Band_Listo pulse, and abortar SHALL have priority over pausa and step advance.
REQ-015 Bandera SHALL be ignored outside IDLE, and a Bandera held high in IDLE after completion SHALL restart the sequence.
REQ-016 A prog_we write SHALL be accepted only in IDLE and SHALL be ignored in RUN/PAUSA, and a write takes effect for the next sequence.
REQ-017 The microcode table SHALL be N_PASOS x W_MICRO registers.

Reset
REQ-018 Reset SHALL force IDLE, paso=0, all outputs 0, and the default program (fields const,fun,acum,senal):
  steps 0..5 = (5,0,2,0), (0,2,0,0), (1,3,0,1), (2,1,1,0), (3,2,0,0), (4,3,0,0), and all further steps 0.
  Reset asserted mid-sequence SHALL take effect immediately and asynchronously, with no Band_Listo.

Configuration
REQ-019 With SECUENCIADOR_REPETIR_EN defined, continuo=1 sampled on the step L-1 cycle SHALL pulse Band_Listo, set paso to 0 and stay in RUN (no IDLE gap).
REQ-020 Without SECUENCIADOR_REPETIR_EN, continuo SHALL be present but ignored, and the behaviour SHALL be per REQ-010.

Verification
REQ-021 Reset, then Bandera for 1 cycle with num_pasos=6 -> six cycles of the default words in order, Senal=1 only at paso=2, Band_Listo=1 only at paso=5, then IDLE.
REQ-022 Write step 0 = (7,3,3,1) in IDLE with num_pasos=1, then Bandera -> one RUN cycle with sel_const=7, sel_fun=3, sel_acum=3, Senal=1, Band_Listo=1.
REQ-023 pausa=1 for 3 cycles at paso=2 -> paso holds at 2 with Senal=0; after release, paso=2 repeats with Senal=1, then 3, and completion is delayed by 3 cycles.
REQ-024 abortar at paso=3, with a prog_we write issued during RUN -> IDLE next cycle, no Band_Listo, and the table is unchanged.
REQ-025 With SECUENCIADOR_REPETIR_EN defined, continuo=1 and num_pasos=0 -> paso wraps N_PASOS-1->0, with Band_Listo every N_PASOS cycles and Ocupado never low.
